// File: rtl/shared_counters.sv
// Pool of n g-bit slices carved at run time into variable-width counters.
// Supports first-fit allocation, increment, free, parallel load and serial read-out.
module shared_counters #(
    parameter int n = 10,
    parameter int g = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              command_in,
    input  logic [$clog2(n)-1:0]    id,
    input  logic [31:0]             new_counter_size,
    output logic [$clog2(n):0]      allocation_id,
    output logic                    valid_allocation_id,
    input  logic [63:0]             load_data_in,
    input  logic                    valid_load_data,
    output logic [g-1:0]            rdata_out,
    output logic                    valid_data_out,
    output logic                    last,
    output logic [n-1:0][g-1:0]     data_out
);

    localparam int IW = $clog2(n);
    localparam int LW = 64 + (2**IW) * g;

    localparam logic [2:0] CMD_INCR    = 3'b001;
    localparam logic [2:0] CMD_NEW     = 3'b010;
    localparam logic [2:0] CMD_DEALLOC = 3'b011;
    localparam logic [2:0] CMD_LOAD    = 3'b100;
    localparam logic [2:0] CMD_READ    = 3'b101;

    typedef enum logic [1:0] {RD_IDLE, RD_STREAM, RD_HOLD} rd_state_t;

    logic [n-1:0][g-1:0] data_reg, data_next;
    logic [n-1:0]        free_reg, free_next;
    logic [n-1:0]        head_reg, head_next;
    logic [n-1:0]        tail_reg, tail_next;
    logic [IW:0]         alloc_id_reg, alloc_id_next;
    logic                alloc_vld_reg, alloc_vld_next;

    rd_state_t           rd_state_reg, rd_state_next;
    logic [IW-1:0]       rd_ptr_reg, rd_ptr_next;
    logic [IW-1:0]       rd_top_reg, rd_top_next;
    logic [g-1:0]        rdata_reg, rdata_next;
    logic                rvalid_reg, rvalid_next;
    logic                rlast_reg, rlast_next;

    logic                id_ok;
    logic [IW-1:0]       top;
    logic [n-1:0]        in_cnt;
    logic [n-1:0][g-1:0] incr_val;
    logic [n-1:0][g-1:0] load_val;
    logic [LW-1:0]       ld_ext;
    logic                carry, carry_in;
    logic                size_ok, fit_ok, fit_found;
    int                  size_int, fit_b;
    logic [IW-1:0]       rd_sel;
    logic [g-1:0]        rd_sel_data;

    assign ld_ext = {{(LW-64){1'b0}}, load_data_in};

    // id is a valid counter only when it names a base slice
    always_comb begin
        id_ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (id == IW'(i) && head_reg[i]) id_ok = 1'b1;
        end
    end

    // top slice of the addressed counter = first tail at or above id
    always_comb begin
        top = IW'(n - 1);
        for (int i = n - 1; i >= 0; i--) begin
            if (tail_reg[i] && IW'(i) >= id) top = IW'(i);
        end
    end

    // Carry injected at the base slice; only in_cnt slices take the result,
    // so a carry out of the top slice never reaches a neighbour.
    always_comb begin
        carry    = 1'b0;
        carry_in = 1'b0;
        incr_val = '0;
        for (int i = 0; i < n; i++) begin
            carry_in    = carry | (id == IW'(i));
            incr_val[i] = data_reg[i] + {{(g-1){1'b0}}, carry_in};
            carry       = carry_in & (&data_reg[i]);
        end
    end

    for (genvar gi = 0; gi < n; gi++) begin : g_slice
        logic [IW-1:0] off;
        assign in_cnt[gi]   = id_ok && (IW'(gi) >= id) && (IW'(gi) <= top);
        assign off          = IW'(gi) - id;
        assign load_val[gi] = ld_ext[off*g +: g];
    end

    // First-fit search: scanning downward leaves the lowest fitting base
    always_comb begin
        size_ok   = (new_counter_size != 32'd0) && (new_counter_size <= 32'(n));
        size_int  = size_ok ? int'(new_counter_size[IW:0]) : 0;
        fit_found = 1'b0;
        fit_b     = 0;
        fit_ok    = 1'b0;
        for (int b = n - 1; b >= 0; b--) begin
            fit_ok = size_ok && (b + size_int <= n);
            for (int i = 0; i < n; i++) begin
                if (i >= b && i < b + size_int && !free_reg[i]) fit_ok = 1'b0;
            end
            if (fit_ok) begin
                fit_found = 1'b1;
                fit_b     = b;
            end
        end
    end

    always_comb begin
        data_next      = data_reg;
        free_next      = free_reg;
        head_next      = head_reg;
        tail_next      = tail_reg;
        alloc_id_next  = alloc_id_reg;
        alloc_vld_next = 1'b0;
        case (command_in)
            CMD_INCR: begin
                for (int i = 0; i < n; i++)
                    if (in_cnt[i]) data_next[i] = incr_val[i];
            end
            CMD_NEW: begin
                if (fit_found) begin
                    for (int i = 0; i < n; i++) begin
                        if (i >= fit_b && i < fit_b + size_int) begin
                            free_next[i] = 1'b0;
                            data_next[i] = '0;
                        end
                        if (i == fit_b) head_next[i] = 1'b1;
                        if (i == fit_b + size_int - 1) tail_next[i] = 1'b1;
                    end
                    alloc_id_next  = (IW+1)'(fit_b);
                    alloc_vld_next = 1'b1;
                end else begin
                    alloc_id_next = (IW+1)'(n);
                end
            end
            CMD_DEALLOC: begin
                for (int i = 0; i < n; i++) begin
                    if (in_cnt[i]) begin
                        free_next[i] = 1'b1;
                        head_next[i] = 1'b0;
                        tail_next[i] = 1'b0;
                        data_next[i] = '0;
                    end
                end
            end
            CMD_LOAD: begin
                if (valid_load_data) begin
                    for (int i = 0; i < n; i++)
                        if (in_cnt[i]) data_next[i] = load_val[i];
                end
            end
            default: ;
        endcase
    end

    // Read FSM: first slice comes from id, later ones from the latched pointer
    assign rd_sel = (rd_state_reg == RD_IDLE) ? id : rd_ptr_reg;

    always_comb begin
        rd_sel_data = '0;
        for (int i = 0; i < n; i++)
            if (rd_sel == IW'(i)) rd_sel_data = data_reg[i];
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        rd_ptr_next   = rd_ptr_reg;
        rd_top_next   = rd_top_reg;
        rdata_next    = rdata_reg;
        rvalid_next   = 1'b0;
        rlast_next    = 1'b0;
        case (rd_state_reg)
            RD_IDLE: begin
                if (command_in == CMD_READ && id_ok) begin
                    rdata_next    = rd_sel_data;
                    rvalid_next   = 1'b1;
                    rlast_next    = (id == top);
                    rd_ptr_next   = id + 1'b1;
                    rd_top_next   = top;
                    rd_state_next = (id == top) ? RD_HOLD : RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (command_in != CMD_READ) begin
                    rd_state_next = RD_IDLE;
                end else begin
                    rdata_next  = rd_sel_data;
                    rvalid_next = 1'b1;
                    rlast_next  = (rd_ptr_reg == rd_top_reg);
                    rd_ptr_next = rd_ptr_reg + 1'b1;
                    if (rd_ptr_reg == rd_top_reg) rd_state_next = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (command_in != CMD_READ) rd_state_next = RD_IDLE;
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg      <= '0;
            free_reg      <= '1;
            head_reg      <= '0;
            tail_reg      <= '0;
            alloc_id_reg  <= '0;
            alloc_vld_reg <= 1'b0;
            rd_state_reg  <= RD_IDLE;
            rd_ptr_reg    <= '0;
            rd_top_reg    <= '0;
            rdata_reg     <= '0;
            rvalid_reg    <= 1'b0;
            rlast_reg     <= 1'b0;
        end else begin
            data_reg      <= data_next;
            free_reg      <= free_next;
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            alloc_id_reg  <= alloc_id_next;
            alloc_vld_reg <= alloc_vld_next;
            rd_state_reg  <= rd_state_next;
            rd_ptr_reg    <= rd_ptr_next;
            rd_top_reg    <= rd_top_next;
            rdata_reg     <= rdata_next;
            rvalid_reg    <= rvalid_next;
            rlast_reg     <= rlast_next;
        end
    end

    assign data_out            = data_reg;
    assign allocation_id       = alloc_id_reg;
    assign valid_allocation_id = alloc_vld_reg;
    assign rdata_out           = rdata_reg;
    assign valid_data_out      = rvalid_reg;
    assign last                = rlast_reg;

endmodule

// File: tb/tb_shared_counters.sv
// Directed bench for shared_counters: a vector table of single-cycle commands
// followed by hand-written multi-cycle sequences (long increment, reads, reset).
module tb_shared_counters;

    localparam int N = 10;
    localparam int G = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        command_in;
    logic [3:0]        id;
    logic [31:0]       new_counter_size;
    logic [4:0]        allocation_id;
    logic              valid_allocation_id;
    logic [63:0]       load_data_in;
    logic              valid_load_data;
    logic [G-1:0]      rdata_out;
    logic              valid_data_out;
    logic              last;
    logic [N-1:0][G-1:0] data_out;

    int checks = 0;
    int errors = 0;

    shared_counters #(.n(N), .g(G)) dut (
        .clk(clk), .rst(rst), .command_in(command_in), .id(id),
        .new_counter_size(new_counter_size), .allocation_id(allocation_id),
        .valid_allocation_id(valid_allocation_id), .load_data_in(load_data_in),
        .valid_load_data(valid_load_data), .rdata_out(rdata_out),
        .valid_data_out(valid_data_out), .last(last), .data_out(data_out)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] C_IDLE = 3'b000, C_INCR = 3'b001, C_NEW = 3'b010,
                           C_DEAL = 3'b011, C_LOAD = 3'b100, C_READ = 3'b101;

    typedef struct {
        logic [2:0]  cmd;
        logic [3:0]  id;
        logic [31:0] size;
        logic [63:0] ld;
        logic        vld;
        logic        chk_aid;
        logic [4:0]  exp_aid;
        logic        exp_valid;
        logic [39:0] exp_data;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [2:0] cmd, input logic [3:0] vid,
                                input logic [31:0] size, input logic [63:0] ld,
                                input logic vld, input logic chk_aid,
                                input logic [4:0] exp_aid, input logic exp_valid,
                                input logic [39:0] exp_data);
        vec_t v;
        v.cmd = cmd; v.id = vid; v.size = size; v.ld = ld; v.vld = vld;
        v.chk_aid = chk_aid; v.exp_aid = exp_aid; v.exp_valid = exp_valid;
        v.exp_data = exp_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] cmd, input logic [3:0] vid,
                         input logic [31:0] size, input logic [63:0] ld, input logic vld);
        command_in = cmd; id = vid; new_counter_size = size;
        load_data_in = ld; valid_load_data = vld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_read(input string name, input logic exp_v, input logic [3:0] exp_r,
                            input logic exp_l);
        chk({name, ".valid"}, 64'(valid_data_out), 64'(exp_v));
        chk({name, ".rdata"}, 64'(rdata_out), 64'(exp_r));
        chk({name, ".last"}, 64'(last), 64'(exp_l));
        $display("%s: valid=%0b rdata=%0h last=%0b", name, valid_data_out, rdata_out, last);
    endtask

    initial begin
        // slices listed 9..0 in exp_data
        vecs[0]  = mk(C_NEW,  0, 3,  0, 0, 1, 5'd0,  1, 40'h0);
        vecs[1]  = mk(C_NEW,  0, 1,  0, 0, 1, 5'd3,  1, 40'h0);
        vecs[2]  = mk(C_NEW,  0, 4,  0, 0, 1, 5'd4,  1, 40'h0);
        vecs[3]  = mk(C_NEW,  0, 2,  0, 0, 1, 5'd8,  1, 40'h0);
        vecs[4]  = mk(C_NEW,  0, 1,  0, 0, 1, 5'd10, 0, 40'h0);
        vecs[5]  = mk(C_DEAL, 3, 0,  0, 0, 0, 5'd0,  0, 40'h0);
        vecs[6]  = mk(C_DEAL, 4, 0,  0, 0, 0, 5'd0,  0, 40'h0);
        vecs[7]  = mk(C_NEW,  0, 5,  0, 0, 1, 5'd3,  1, 40'h0);
        vecs[8]  = mk(C_NEW,  0, 6,  0, 0, 1, 5'd10, 0, 40'h0);
        vecs[9]  = mk(C_NEW,  0, 0,  0, 0, 1, 5'd10, 0, 40'h0);
        vecs[10] = mk(C_LOAD, 0, 0,  64'hFFF, 1, 0, 5'd0, 0, 40'h00_0000_0FFF);
        vecs[11] = mk(C_LOAD, 3, 0,  64'h12345, 1, 0, 5'd0, 0, 40'h00_1234_5FFF);
        vecs[12] = mk(C_INCR, 0, 0,  0, 0, 0, 5'd0,  0, 40'h00_1234_5000);
        vecs[13] = mk(C_LOAD, 3, 0,  64'h99999, 0, 0, 5'd0, 0, 40'h00_1234_5000);
        vecs[14] = mk(C_INCR, 5, 0,  0, 0, 0, 5'd0,  0, 40'h00_1234_5000);
        vecs[15] = mk(C_LOAD, 1, 0,  64'h777, 1, 0, 5'd0, 0, 40'h00_1234_5000);
        vecs[16] = mk(3'b110, 0, 0,  64'h777, 1, 0, 5'd0, 0, 40'h00_1234_5000);
        vecs[17] = mk(C_LOAD, 0, 0,  64'hAAAA_AAAA_AAAA_AAAA, 1, 0, 5'd0, 0, 40'h00_1234_5AAA);
        vecs[18] = mk(C_INCR, 8, 0,  0, 0, 0, 5'd0,  0, 40'h01_1234_5AAA);
        vecs[19] = mk(C_LOAD, 8, 0,  64'hFF, 1, 0, 5'd0, 0, 40'hFF_1234_5AAA);
        vecs[20] = mk(C_INCR, 8, 0,  0, 0, 0, 5'd0,  0, 40'h00_1234_5AAA);
        vecs[21] = mk(C_NEW,  0, 11, 0, 0, 1, 5'd10, 0, 40'h00_1234_5AAA);
        vecs[22] = mk(C_NEW,  0, 32'h8000_0003, 0, 0, 1, 5'd10, 0, 40'h00_1234_5AAA);
        vecs[23] = mk(C_DEAL, 2, 0,  0, 0, 0, 5'd0,  0, 40'h00_1234_5AAA);
        vecs[24] = mk(C_LOAD, 0, 0,  0, 1, 0, 5'd0,  0, 40'h00_1234_5000);

        rst = 1'b1;
        drive(C_NEW, 0, 2, 0, 0);
        step(); step();
        chk("reset.aid", 64'(allocation_id), 64'd0);
        chk("reset.aid_valid", 64'(valid_allocation_id), 64'd0);
        chk("reset.data", 64'(data_out), 64'd0);
        chk_read("reset", 1'b0, 4'h0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].cmd, vecs[i].id, vecs[i].size, vecs[i].ld, vecs[i].vld);
            step();
            if (vecs[i].chk_aid)
                chk($sformatf("vec%0d.aid", i), 64'(allocation_id), 64'(vecs[i].exp_aid));
            chk($sformatf("vec%0d.aid_valid", i), 64'(valid_allocation_id), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.data", i), 64'(data_out), 64'(vecs[i].exp_data));
            $display("vec %0d cmd=%0b id=%0d aid=%0d v=%0b data=%h", i, vecs[i].cmd,
                     vecs[i].id, allocation_id, valid_allocation_id, data_out);
        end

        // 10000 increments of the 12-bit counter at 0
        drive(C_INCR, 0, 0, 0, 0);
        repeat (10000) @(posedge clk);
        #1;
        drive(C_IDLE, 0, 0, 0, 0);
        chk("incr10000.data", 64'(data_out), 64'h00_1234_5710);
        $display("incr x10000 id=0 data=%h", data_out);

        // full read of counter 0 (0x710)
        drive(C_READ, 0, 0, 0, 0);
        step(); chk_read("rd0.s0", 1'b1, 4'h0, 1'b0);
        step(); chk_read("rd0.s1", 1'b1, 4'h1, 1'b0);
        step(); chk_read("rd0.s2", 1'b1, 4'h7, 1'b1);
        step(); chk_read("rd0.after", 1'b0, 4'h7, 1'b0);
        step(); chk_read("rd0.hold", 1'b0, 4'h7, 1'b0);
        drive(C_IDLE, 0, 0, 0, 0);
        step();

        // read of counter 3 aborted after two slices
        drive(C_READ, 3, 0, 0, 0);
        step(); chk_read("rd3.s0", 1'b1, 4'h5, 1'b0);
        step(); chk_read("rd3.s1", 1'b1, 4'h4, 1'b0);
        drive(C_IDLE, 0, 0, 0, 0);
        step(); chk_read("rd3.abort", 1'b0, 4'h4, 1'b0);

        // read on a non-base id is ignored
        drive(C_READ, 5, 0, 0, 0);
        step(); chk_read("rd5.nobase", 1'b0, 4'h4, 1'b0);
        drive(C_IDLE, 0, 0, 0, 0);
        step();

        // reset in the middle of a read
        drive(C_READ, 3, 0, 0, 0);
        step(); chk_read("rdrst.s0", 1'b1, 4'h5, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_read("rdrst.reset", 1'b0, 4'h0, 1'b0);
        chk("rdrst.data", 64'(data_out), 64'd0);
        drive(C_NEW, 0, 10, 0, 0);
        step();
        chk("rdrst.newfull.aid", 64'(allocation_id), 64'd0);
        chk("rdrst.newfull.valid", 64'(valid_allocation_id), 64'd1);
        $display("post-reset new size 10 aid=%0d v=%0b", allocation_id, valid_allocation_id);
        drive(C_IDLE, 0, 0, 0, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
